// File: rtl/weight_seq_ctrl_if.sv
// Handshake and memory bus bundle for weight_seq_ctrl.
// WMEM_LOAD_EN adds the weight-memory load (cfg_* / mem_w*) signals.
interface weight_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_radd;
    logic [DATA_W-1:0] mem_wout;
    logic              mac_valid;
    logic [DATA_W-1:0] mac_x;
    logic [DATA_W-1:0] mac_w;
    logic              mac_first;
    logic              mac_last;
    logic              busy;
    logic              done;
`ifdef WMEM_LOAD_EN
    logic              cfg_wen;
    logic [ADDR_W-1:0] cfg_wadd;
    logic [DATA_W-1:0] cfg_win;
    logic              cfg_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_wadd;
    logic [DATA_W-1:0] mem_win;
`endif

    // Sequencer side.
    modport slave (
        input  start, in_valid, in_data, mem_wout,
`ifdef WMEM_LOAD_EN
        input  cfg_wen, cfg_wadd, cfg_win,
        output cfg_ready, mem_wen, mem_wadd, mem_win,
`endif
        output in_ready, mem_ren, mem_radd, mac_valid, mac_x, mac_w,
        output mac_first, mac_last, busy, done
    );

    // Environment side: activation source, weight memory and MAC.
    modport master (
        output start, in_valid, in_data, mem_wout,
`ifdef WMEM_LOAD_EN
        output cfg_wen, cfg_wadd, cfg_win,
        input  cfg_ready, mem_wen, mem_wadd, mem_win,
`endif
        input  in_ready, mem_ren, mem_radd, mac_valid, mac_x, mac_w,
        input  mac_first, mac_last, busy, done
    );
endinterface

// File: rtl/weight_seq_ctrl.sv
// Walks one neuron's weight memory in step with an activation stream and feeds aligned
// {x, w} pairs to the MAC. Define WMEM_LOAD_EN to add the idle-time weight load port.
module weight_seq_ctrl #(
    parameter int unsigned NUM_WEIGHT = 30,
    parameter int unsigned ADDR_W     = $clog2(NUM_WEIGHT),
    parameter int unsigned DATA_W     = 16
) (
    input logic              clk,
    input logic              rst,
    weight_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_WEIGHT - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] radd_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              mac_valid_q;
    logic              mac_first_q;
    logic              mac_last_q;
    logic [DATA_W-1:0] mac_x_q;
    logic              accept;

    assign accept = bus.in_valid & in_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            radd_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            mac_x_q     <= '0;
        end else begin
            // The x register lines up with the memory's one-cycle read latency.
            mac_valid_q <= accept;
            mac_first_q <= accept & (idx_q == '0);
            mac_last_q  <= accept & (idx_q == LastIdx);
            done_q      <= 1'b0;
            if (accept) begin
                mac_x_q <= bus.in_data;
                radd_q  <= idx_q;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q    <= StRun;
                        idx_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (idx_q == LastIdx) begin
                            idx_q      <= '0;
                            state_q    <= StDrain;
                            in_ready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                // Last weight is still in flight from the memory.
                StDrain: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_ren   = accept;
    assign bus.mem_radd  = accept ? idx_q : radd_q;
    assign bus.mac_valid = mac_valid_q;
    assign bus.mac_x     = mac_x_q;
    assign bus.mac_w     = bus.mem_wout;
    assign bus.mac_first = mac_first_q;
    assign bus.mac_last  = mac_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef WMEM_LOAD_EN
    logic cfg_ready;

    // A coincident start takes priority; the requester keeps cfg_wen up until accepted.
    assign cfg_ready     = (state_q == StIdle) & ~bus.start;
    assign bus.cfg_ready = cfg_ready;
    assign bus.mem_wen   = bus.cfg_wen & cfg_ready;
    assign bus.mem_wadd  = bus.cfg_wadd;
    assign bus.mem_win   = bus.cfg_win;
`endif
endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Randomised scoreboard bench for weight_seq_ctrl against a pass-level reference model.
// Compile with WMEM_LOAD_EN defined to also exercise the weight load port.
module tb_weight_seq_ctrl;
    localparam int NW = 30;
    localparam int AW = $clog2(NW);
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    weight_seq_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    weight_seq_ctrl #(.NUM_WEIGHT(NW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Weight memory with registered read; exp_mem is the bench's own view of its contents.
    logic [DW-1:0] mem     [NW];
    logic [DW-1:0] exp_mem [NW];
    logic [DW-1:0] wout;
    always @(posedge clk) begin
        if (bus.mem_ren) wout <= mem[bus.mem_radd];
`ifdef WMEM_LOAD_EN
        if (bus.mem_wen) mem[bus.mem_wadd] <= bus.mem_win;
`endif
    end
    assign bus.mem_wout = wout;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] w;
        logic          first;
        logic          last;
    } beat_t;

    beat_t sb[$];

    // Pass-level model: k = next pair index, running = activations wanted,
    // active = pass in progress, dcnt = cycles until done is due.
    int            k;
    bit            active;
    bit            running;
    int            dcnt;
    int            beats;
    logic [AW-1:0] last_radd;

    initial begin : monitor
        bit    acc;
        bit    act0;
        beat_t b;
`ifdef WMEM_LOAD_EN
        bit    exp_rdy;
`endif
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                k = 0; active = 0; running = 0; dcnt = 0; beats = 0; last_radd = '0;
            end else begin
                act0 = active;
                acc  = bus.in_valid && running;
                chk("in_ready", 32'(bus.in_ready), 32'(running));
                chk("busy", 32'(bus.busy), 32'(active));
                chk("done", 32'(bus.done), 32'(dcnt == 1));
                chk("mem_ren", 32'(bus.mem_ren), 32'(acc));
                chk("mem_radd", 32'(bus.mem_radd), acc ? 32'(k) : 32'(last_radd));
                chk("mac_valid", 32'(bus.mac_valid), 32'(sb.size() != 0));
                if (bus.mac_valid && sb.size() != 0) begin
                    b = sb.pop_front();
                    beats++;
                    chk("mac_x", 32'(bus.mac_x), 32'(b.x));
                    chk("mac_w", 32'(bus.mac_w), 32'(b.w));
                    chk("mac_first", 32'(bus.mac_first), 32'(b.first));
                    chk("mac_last", 32'(bus.mac_last), 32'(b.last));
                end
`ifdef WMEM_LOAD_EN
                exp_rdy = !active && !bus.start;
                chk("cfg_ready", 32'(bus.cfg_ready), 32'(exp_rdy));
                chk("mem_wen", 32'(bus.mem_wen), 32'(bus.cfg_wen && exp_rdy));
                if (bus.cfg_wen && exp_rdy) begin
                    chk("mem_wadd", 32'(bus.mem_wadd), 32'(bus.cfg_wadd));
                    chk("mem_win", 32'(bus.mem_win), 32'(bus.cfg_win));
                    exp_mem[bus.cfg_wadd] = bus.cfg_win;
                end
`endif
                if (dcnt > 0) begin
                    if (dcnt == 1) active = 0;
                    dcnt--;
                end
                if (acc) begin
                    sb.push_back('{x: bus.in_data, w: exp_mem[k], first: (k == 0),
                                   last: (k == NW - 1)});
                    last_radd = AW'(k);
                    if (k == NW - 1) begin
                        running = 0; dcnt = 2; k = 0;
                    end else begin
                        k++;
                    end
                end
                if (bus.start && !act0) begin
                    active = 1; running = 1; k = 0; beats = 0;
                end
            end
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // mode 0: continuous, x = index; 1: alternate valid; 2: random valid and data.
    task automatic drive_pass(input int mode, input int stop_after, input int repulse_at);
        int n = 0;
        int cyc = 0;
        bit rp = 0;
        bit acc;
        while (n < NW && n != stop_after && cyc < 400) begin
            case (mode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (cyc % 2 == 0);
                default: bus.in_valid = ($urandom_range(0, 9) < 7);
            endcase
            bus.in_data = (mode == 0) ? DW'(n) : DW'($urandom);
            if (n == repulse_at && !rp) begin
                bus.start = 1'b1;
                rp = 1;
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (acc) n++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (cyc >= 400) chk("drive_budget", 32'(n), 32'(NW));
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        @(posedge clk); #1;
        chk("done_seen", 32'(seen), 32'd1);
        chk("pass_beats", 32'(beats), 32'(NW));
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mem_ren", 32'(bus.mem_ren), 32'd0);
        chk("rst_mem_radd", 32'(bus.mem_radd), 32'd0);
        chk("rst_mac_valid", 32'(bus.mac_valid), 32'd0);
        chk("rst_mac_first", 32'(bus.mac_first), 32'd0);
        chk("rst_mac_last", 32'(bus.mac_last), 32'd0);
        chk("rst_mac_x", 32'(bus.mac_x), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        bit ok;
        for (int i = 0; i < NW; i++) begin
            mem[i]     = DW'(i + 100);
            exp_mem[i] = DW'(i + 100);
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
`ifdef WMEM_LOAD_EN
        bus.cfg_wen  = 1'b0;
        bus.cfg_wadd = '0;
        bus.cfg_win  = '0;
`endif
        @(posedge clk); #1;
        do_reset();

        // Continuous stream.
        pulse_start();
        drive_pass(0, -1, -1);
        wait_done();

        // Alternating bubbles.
        pulse_start();
        drive_pass(1, -1, -1);
        wait_done();

        // Start re-pulsed mid-pass is ignored.
        pulse_start();
        drive_pass(2, -1, 12);
        wait_done();

        // Abort after 17 accepts, then a clean full pass.
        pulse_start();
        drive_pass(2, 17, -1);
        do_reset();
        pulse_start();
        drive_pass(0, -1, -1);
        wait_done();

        // Back-to-back passes.
        pulse_start();
        drive_pass(2, -1, -1);
        wait_done();
        pulse_start();
        drive_pass(0, -1, -1);
        wait_done();

`ifdef WMEM_LOAD_EN
        // Write coincident with start, held through the busy pass, lands once idle.
        bus.cfg_wen  = 1'b1;
        bus.cfg_wadd = AW'(5);
        bus.cfg_win  = 16'hBEEF;
        pulse_start();
        drive_pass(2, -1, -1);
        wait_done();
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cfg_ready;
            @(posedge clk); #1;
        end
        bus.cfg_wen = 1'b0;
        chk("cfg_accepted", 32'(ok), 32'd1);
        chk("mem5_written", 32'(mem[5]), 32'hBEEF);
        pulse_start();
        drive_pass(0, -1, -1);
        wait_done();
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
